perceptron_stream_core: RTL
===========================

// Module: perceptron_stream_core
// PURPOSE
//  Parametrised N-input perceptron engine driven by a byte stream from the UART receiver and answering
//  through the UART transmitter. Host loads weights and bias ('W') and input vectors ('X').
//  It evaluates y = step(bias + sum w_i*x_i) with a sequential signed MAC and returns the result byte.
//  Generalises the fixed 2-input Q4.4 perceptron in channel count, word width and response mode.
// PARAMETERS
//  fp_integer_width  4      integer bits of signed fixed point (incl. sign); W = int+fract
//  fp_fract_width    4      fractional bits
//  n_inputs          2      number of inputs/weights N (1..64)
//  timeout_cycles    120000 idle clk cycles allowed between payload bytes before abort (10 ms @12 MHz)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous reset, active-high
//  rx_data   in   8   received byte, valid while rx_valid
//  rx_valid  in   1   one-cycle strobe per received byte
//  tx_data   out  8   byte to transmit
//  tx_valid  out  1   tx_data valid; held until tx_ready
//  tx_ready  in   1   transmitter accepts byte when tx_valid&tx_ready
//  busy      out  1   high in every state except IDLE
//  y         out  1   last classification result
// BEHAVIOUR
//  Reset (async, any state): tx_valid=0, tx_data=0, busy=0, y=0, weights+bias=0, FSM->IDLE, timer=0.
//  Words: BPW=ceil(W/8) bytes each, little-endian; unused MSBs of the top byte are ignored.
//  FSM: IDLE -> LOAD_W | LOAD_X -> (MAC -> ACT) -> SEND -> IDLE.
//   IDLE: 0x57 'W' -> LOAD_W; 0x58 'X' -> LOAD_X; any other byte -> SEND with 0x15 (NAK).
//   LOAD_W: takes (N+1)*BPW bytes: w0..w(N-1) then bias, into shadow regs. Commits all atomically
//     on the final byte -> SEND 0x06 (ACK). A partial load never changes the live weights.
//   LOAD_X: takes N*BPW bytes x0..x(N-1); final byte -> MAC.
//   Timeout: in LOAD_*, timer resets on each rx_valid. Reaching timeout_cycles -> SEND 0x15.
//     Live weights and y are unchanged.
//   MAC: acc <= sext(bias)<<F, then one product w_i*x_i per cycle, N cycles total.
//   ACT: y <= (acc > 0); acc == 0 gives y=0. Result byte = {7'b0, y}.
//   Latency: final input byte captured in cycle t -> tx_valid first high in cycle t+N+2.
//   SEND: tx_valid=1 with stable tx_data until the tx_valid&tx_ready cycle; then tx_valid=0 next
//     cycle and FSM -> IDLE (or next raw byte).
//  Arithmetic: signed two's complement Q(I.F); product 2W bits Q(2I.2F).
//   acc width 2W+clog2(N+1); no overflow is possible.
//  rx_valid in MAC/ACT/SEND is dropped (no queueing). A byte arriving in the same cycle as the
//   return to IDLE is dropped.
//  tx_ready high while tx_valid low has no effect.
// CONFIGURATION
//  PERCEPTRON_RAW_OUT_EN defined: 'X' responds with BPW bytes, little-endian, of the pre-activation sum
//   sat_W(acc >>> F). Saturation is to the max/min W-bit signed value. y is still updated. SEND
//   emits the bytes back-to-back under the same handshake. Latency to the first byte is unchanged.
//  Not defined: single step byte 0x00/0x01 as above; no saturation logic is built.
// TESTING (defaults: N=2, Q4.4, 1.0=0x10)
//  1 reset, then 'X',0x10,0x10 with zero weights -> tx 0x00, y=0; tx_valid/busy/y all 0 out of reset.
//  2 'W',0x10,0x10,0xE8 -> tx 0x06; 'X',0x10,0x10 -> tx 0x01, y=1 (0.5).
//    Then 'X',0x10,0x00 -> 0x00 (-0.5).
//  3 byte 0x41 in IDLE -> tx 0x15, busy back to 0; following 'X' is processed normally.
//  4 'W',0x20 then silence timeout_cycles -> 0x15.
//    Later 'X',0x10,0x10 gives result of old weights (0x01 after test 2).
//  5 hold tx_ready=0 for 100 cycles during SEND, inject rx bytes -> tx_valid/tx_data stable,
//    bytes dropped, busy=1; check tx_valid timing t+N+2.
//  6 rst pulse mid-MAC -> all outputs 0 immediately, weights cleared;
//    RAW_OUT_EN: test 2 gives 0x08, and w=x=0x70, bias=0x70 gives 0x7F (saturated).

Source files
------------

// File: rtl/perceptron_stream_core.sv
// perceptron_stream_core
//   N-input fixed-point perceptron driven by a UART byte stream.
//   'W' loads N weights then the bias (atomically committed, answered with ACK 0x06).
//   'X' loads N inputs, runs a sequential signed MAC and answers with the result.
//   Any other command byte in IDLE, or an idle gap of timeout_cycles inside a load,
//   answers with NAK 0x15.
//   Words are ceil(W/8) bytes, little-endian, W = fp_integer_width + fp_fract_width.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rx_data/rx_valid   received byte and its one-cycle strobe
//   tx_data/tx_valid   response byte, held until tx_ready
//   tx_ready           transmitter accepts when tx_valid & tx_ready
//   busy               high in every state except IDLE
//   y                  last classification result
// Build option
//   PERCEPTRON_RAW_OUT_EN: 'X' answers with the saturated pre-activation sum
//   (W bits, sent as ceil(W/8) little-endian bytes) instead of the step byte.
`timescale 1ns/1ps
module perceptron_stream_core #(
    parameter int fp_integer_width = 4,
    parameter int fp_fract_width   = 4,
    parameter int n_inputs         = 2,
    parameter int timeout_cycles   = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       y
);
    localparam int W      = fp_integer_width + fp_fract_width;
    localparam int F      = fp_fract_width;
    localparam int N      = n_inputs;
    localparam int BPW    = (W + 7) / 8;
    localparam int BW     = BPW * 8;
    localparam int ACC_W  = 2 * W + $clog2(N + 1);
    localparam int WCNT_W = $clog2(N + 1);
    localparam int BCNT_W = $clog2(BPW + 1);
    localparam int TMR_W  = $clog2(timeout_cycles + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_X = 8'h58;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_MAC, S_ACT, S_SEND
    } state_t;

    state_t                    state;
    logic signed [W-1:0]       w_live   [N];
    logic signed [W-1:0]       w_shadow [N];
    logic signed [W-1:0]       x_reg    [N];
    logic signed [W-1:0]       bias_live;
    logic        [BW-1:0]      word_buf;
    logic        [BCNT_W-1:0]  byte_cnt;
    logic        [WCNT_W-1:0]  word_cnt;
    logic        [TMR_W-1:0]   timer;
    logic signed [ACC_W-1:0]   acc;

    logic        [BW-1:0]      next_word;
    logic signed [W-1:0]       rx_word;
    logic signed [2*W-1:0]     prod;
    logic                      byte_last;
    logic                      timeout_hit;
    logic                      acc_pos;

    // Little-endian assembly: each byte enters at the top and the word shifts down.
    assign next_word   = BW'({rx_data, word_buf} >> 8);
    assign rx_word     = next_word[W-1:0];
    assign byte_last   = (byte_cnt == BCNT_W'(BPW - 1));
    assign timeout_hit = (timer == TMR_W'(timeout_cycles - 1));
    assign prod        = (2*W)'(w_live[0]) * (2*W)'(x_reg[0]);
    assign acc_pos     = !acc[ACC_W-1] && (|acc);

`ifdef PERCEPTRON_RAW_OUT_EN
    logic signed [W-1:0]      sat_val;
    logic        [BW-1:0]     sat_bytes;
    logic        [BW-1:0]     send_buf;
    logic        [BCNT_W-1:0] send_left;

    // acc >>> F fits in W bits only when everything from bit F+W-1 up is pure sign.
    always_comb begin
        sat_val = acc[F+W-1:F];
        if (!(&acc[ACC_W-1:F+W-1]) && (|acc[ACC_W-1:F+W-1]))
            sat_val = acc[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    assign sat_bytes = BW'(sat_val);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            y         <= 1'b0;
            bias_live <= '0;
            word_buf  <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            timer     <= '0;
            acc       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                w_live[i]   <= '0;
                w_shadow[i] <= '0;
                x_reg[i]    <= '0;
            end
`ifdef PERCEPTRON_RAW_OUT_EN
            send_buf  <= '0;
            send_left <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        timer    <= '0;
                        case (rx_data)
                            CMD_W:   state <= S_LOAD_W;
                            CMD_X:   state <= S_LOAD_X;
                            default: begin
                                state    <= S_SEND;
                                tx_valid <= 1'b1;
                                tx_data  <= NAK;
                            end
                        endcase
                    end
                end

                S_LOAD_W, S_LOAD_X: begin
                    if (rx_valid) begin
                        timer    <= '0;
                        word_buf <= next_word;
                        if (!byte_last) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            byte_cnt <= '0;
                            word_cnt <= word_cnt + 1'b1;
                            if (state == S_LOAD_W) begin
                                if (word_cnt == WCNT_W'(N)) begin
                                    // Bias word: commit the complete set in one cycle.
                                    for (int unsigned i = 0; i < N; i++)
                                        w_live[i] <= w_shadow[i];
                                    bias_live <= rx_word;
                                    state     <= S_SEND;
                                    tx_valid  <= 1'b1;
                                    tx_data   <= ACK;
                                end else begin
                                    for (int unsigned i = 0; i + 1 < N; i++)
                                        w_shadow[i] <= w_shadow[i+1];
                                    w_shadow[N-1] <= rx_word;
                                end
                            end else begin
                                for (int unsigned i = 0; i + 1 < N; i++)
                                    x_reg[i] <= x_reg[i+1];
                                x_reg[N-1] <= rx_word;
                                if (word_cnt == WCNT_W'(N - 1)) begin
                                    state    <= S_MAC;
                                    word_cnt <= '0;
                                    acc      <= ACC_W'(bias_live) <<< F;
                                end
                            end
                        end
                    end else if (timeout_hit) begin
                        state    <= S_SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= NAK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // Weights and inputs rotate so element 0 is always the current term;
                // after exactly N rotations the live weights are back in their original order.
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    for (int unsigned i = 0; i + 1 < N; i++) begin
                        w_live[i] <= w_live[i+1];
                        x_reg[i]  <= x_reg[i+1];
                    end
                    w_live[N-1] <= w_live[0];
                    x_reg[N-1]  <= x_reg[0];
                    if (word_cnt == WCNT_W'(N - 1))
                        state <= S_ACT;
                    else
                        word_cnt <= word_cnt + 1'b1;
                end

                S_ACT: begin
                    y        <= acc_pos;
                    state    <= S_SEND;
                    tx_valid <= 1'b1;
`ifdef PERCEPTRON_RAW_OUT_EN
                    tx_data   <= sat_bytes[7:0];
                    send_buf  <= sat_bytes >> 8;
                    send_left <= BCNT_W'(BPW - 1);
`else
                    tx_data   <= {7'b0, acc_pos};
`endif
                end

                S_SEND: begin
                    if (tx_ready) begin
`ifdef PERCEPTRON_RAW_OUT_EN
                        // send_left is only non-zero while a raw sum is going out,
                        // so ACK/NAK always finish after one byte.
                        if (send_left != '0) begin
                            tx_data   <= send_buf[7:0];
                            send_buf  <= send_buf >> 8;
                            send_left <= send_left - 1'b1;
                        end else
`endif
                        begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
